// File: rtl/led_level_writer.sv
// led_level_writer: peak-hold audio level meter driving an LED bar one LED per write strobe
// Ports: clk; reset (sync, active-low); sample/sample_valid (signed audio in);
//        rgb_data/led_num/write (one LED update per strobe); busy (refresh in progress)
module led_level_writer #(
  parameter int NUM_LEDS = 8,
  parameter int REFRESH_CYCLES = 120000,
  parameter int DECAY_SHIFT = 2,
  parameter logic [7:0] BRIGHT = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        busy
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [16:0] STEP = 17'(32768 / NUM_LEDS);
  localparam logic [7:0] LAST = 8'(NUM_LEDS - 1);
  typedef enum logic [1:0] {IDLE, LATCH, WRITE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_peak, r_level, w_mag, w_decayed;
  logic [16:0] r_thr, w_thr;
  logic [7:0] r_idx, w_idx;
  logic [23:0] w_rgb;
  logic r_pending, w_tick, w_start, w_lit;
  assign w_tick = r_cnt == CW'(REFRESH_CYCLES - 1);
  assign w_start = w_tick | r_pending;
  // -32768 negates to itself, which reads as 32768 unsigned
  assign w_mag = sample[15] ? -sample : sample;
  assign w_decayed = w_tick ? r_peak - (r_peak >> DECAY_SHIFT) : r_peak;
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state == IDLE  ? (w_start ? LATCH : IDLE) :
             r_state == LATCH ? WRITE :
             (r_idx == LAST ? IDLE : WRITE);
  end
  // Outputs are registered from the index/threshold the next cycle will hold,
  // so the strobe lines up with the WRITE cycle it describes.
  always_comb begin
    w_idx = r_state == LATCH ? 8'd0 : r_idx + 8'd1;
    w_thr = r_state == LATCH ? STEP : r_thr + STEP;
    w_rgb = w_idx < 8'(NUM_LEDS / 2)     ? {BRIGHT, 16'h0000} :
            w_idx < 8'(3 * NUM_LEDS / 4) ? {BRIGHT, BRIGHT, 8'h00} :
                                           {8'h00, BRIGHT, 8'h00};
    w_lit = w_next == WRITE && {1'b0, r_level} >= w_thr;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_peak <= '0;
      r_level <= '0;
      r_pending <= 1'b0;
      r_idx <= '0;
      r_thr <= '0;
      write <= 1'b0;
      busy <= 1'b0;
      led_num <= '0;
      rgb_data <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_peak <= sample_valid && w_mag > w_decayed ? w_mag : w_decayed;
      r_pending <= r_state == IDLE ? 1'b0 : r_pending | w_tick;
      if (r_state == IDLE && w_start) r_level <= r_peak;
      if (r_state != IDLE) begin
        r_idx <= w_idx;
        r_thr <= w_thr;
      end
      write <= w_next == WRITE;
      busy <= w_next != IDLE;
      led_num <= w_next == WRITE ? w_idx : 8'd0;
      rgb_data <= w_lit ? w_rgb : 24'h0;
    end
  end
endmodule

// File: doc/led_level_writer.md
LED_LEVEL_WRITER -- requirements
Module: led_level_writer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of LEDs in the bar; power of two, 2..128.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 120000: clk cycles between bar updates; value > NUM_LEDS+4.
REQ-003 SHALL have parameter DECAY_SHIFT, default 2: peak decay per refresh is peak>>DECAY_SHIFT.
REQ-004 SHALL have parameter BRIGHT, default 8'h20: byte value of a lit colour channel.
REQ-005 SHALL have port clk  input  1  system clock; one clock domain, all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port sample  input  16  signed two's-complement audio sample.
REQ-008 SHALL have port sample_valid  input  1  sample is valid this cycle; no backpressure.
REQ-009 SHALL have port rgb_data  output  24  colour to the LED driver; [23:16] green, [15:8] red, [7:0] blue (wire order).
REQ-010 SHALL have port led_num  output  8  target LED index, 0..NUM_LEDS-1.
REQ-011 SHALL have port write  output  1  one-cycle strobe; rgb_data/led_num are valid while it is high.
REQ-012 SHALL have port busy  output  1  high while in LATCH or WRITE.

Function
REQ-013 SHALL compute the magnitude as 16-bit unsigned |sample|, with -32768 -> 32768 and no saturation.
REQ-014 SHALL hold a 16-bit peak register; on sample_valid, peak <= max(peak_next, magnitude).
REQ-015 SHALL run a free-running refresh counter that produces a one-cycle tick every REFRESH_CYCLES clks; the first tick comes REFRESH_CYCLES cycles after reset release.
REQ-016 SHALL decay peak on each tick: peak_next = peak - (peak>>DECAY_SHIFT); with a simultaneous sample_valid, peak <= max(decayed peak, magnitude).
REQ-017 SHALL use FSM states IDLE, LATCH, WRITE; on reset the FSM SHALL enter IDLE.
REQ-018 SHALL, in IDLE, on a tick or a set pending flag: level <= peak value before decay, clear pending, go to LATCH.
REQ-019 SHALL, in LATCH, set the LED index to 0 and threshold to STEP = 32768/NUM_LEDS, then go to WRITE.
REQ-020 SHALL, in WRITE, each cycle: write=1, led_num=index, LED lit iff level >= threshold; then index+1, threshold+STEP using 17-bit arithmetic with no wrap.
REQ-021 SHALL return to IDLE after the write with index NUM_LEDS-1; exactly NUM_LEDS consecutive write cycles per refresh.
REQ-022 SHALL use lit colour green {BRIGHT,00,00} for index < NUM_LEDS/2, yellow {BRIGHT,BRIGHT,00} for index < 3*NUM_LEDS/4, else red {00,BRIGHT,00}; unlit = 24'h0.
REQ-023 SHALL register all outputs; with a tick in IDLE at cycle T, the first write is high at T+2.
REQ-024 SHALL, on a tick while busy, set pending; multiple ticks while busy collapse to one.
REQ-025 SHALL keep write=0, led_num=0, rgb_data=0 whenever not in WRITE.

Reset
REQ-026 SHALL, on reset low at a clk edge, clear peak, level, refresh counter, pending, index, threshold and state=IDLE.
REQ-027 SHALL, during reset, force write=0, busy=0, led_num=0, rgb_data=0.
REQ-028 SHALL abort a WRITE sequence on reset mid-sequence with no further write strobes; after release, wait a full REFRESH_CYCLES.
REQ-029 SHALL ignore sample_valid while reset is low.

Verification (NUM_LEDS=8, REFRESH_CYCLES=100, DECAY_SHIFT=2, BRIGHT=8'h20)
REQ-030 SHALL check: reset low 5 cycles, then high with no samples -> outputs 0; at first tick +2, 8 writes of 24'h0, led_num 0..7.
REQ-031 SHALL check: one sample 16'h4000 then a tick -> LEDs 0-3 = 24'h200000, LEDs 4-7 = 0; busy high for 9 cycles.
REQ-032 SHALL check: sample 16'h8000 (-32768) -> LEDs 0-3 24'h200000, 4-5 24'h202000, 6-7 24'h002000.
REQ-033 SHALL check: peak 16384 with no further samples -> refresh 1 lights 4 LEDs, refresh 2 (level 12288) lights 3, refresh 3 (9216) lights 2.
REQ-034 SHALL check: sample_valid with magnitude 20000 on the tick cycle, peak 16384 -> latched level 16384, new peak 20000.
REQ-035 SHALL check: reset low during the 3rd write -> write=0 the next cycle and no writes until 100 cycles after release.
